// File: rtl/core_pkg.sv
// Shared RV32I decode definitions: opcodes, funct encodings and the
// operand bundle handed from decode to the ALU.
package core_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic        illegal;
  } alu_op_t;

  // The alternate funct7 is only defined for SUB/SRA (register form)
  // and SRAI (immediate shift form).
  function automatic logic f7_legal(input logic [2:0] f3, input logic [6:0] f7,
                                    input logic is_imm_shift);
    logic alt_ok;
    alt_ok = is_imm_shift ? (f3 == F3_SR) : ((f3 == F3_ADD) || (f3 == F3_SR));
    return (f7 == F7_BASE) || ((f7 == F7_ALT) && alt_ok);
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Handshake bundle around the decode stage: fetch-side input, ALU-side
// output and the writeback return port.
interface decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd;
  logic        out_illegal;

  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    input  in_ready, out_valid, out_a, out_b, out_funct3, out_funct7,
           out_rd, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_rd, wb_data,
    output in_ready, out_valid, out_a, out_b, out_funct3, out_funct7,
           out_rd, out_illegal
  );
endinterface

// File: rtl/decode_stage_regfile.sv
// Architectural register file: two combinational read ports with
// write-through bypass, one synchronous write port, x0 fixed at zero.
module regfile
  import core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] regs_reg [NREG];
  logic            wr_live;

  assign wr_live = wr_en && (wr_addr != 5'd0);

  // Every entry must come out of reset as zero, so storage is flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_reg[i] <= '0;
    end else if (wr_live) begin
      regs_reg[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rs1_data = '0;
    if (rs1_addr != 5'd0) begin
      rs1_data = (wr_live && wr_addr == rs1_addr) ? wr_data : regs_reg[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != 5'd0) begin
      rs2_data = (wr_live && wr_addr == rs2_addr) ? wr_data : regs_reg[rs2_addr];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode/operand stage: decodes OP, OP-IMM and LUI, reads operands,
// tracks in-flight destinations and registers one ALU operation.
module decode_stage
  import core_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  decode_stage_if.slave  bus
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  alu_op_t         dec;
  logic            legal;
  logic            use_rs1;
  logic            use_rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            hazard;
  logic            in_ready;
  logic            accept;

  alu_op_t         out_reg;
  alu_op_t         out_next;
  logic            out_valid_reg;
  logic            out_valid_next;
  logic [NREG-1:0] pending_reg;
  logic [NREG-1:0] pending_next;

  assign opcode = bus.in_instr[6:0];
  assign rd     = bus.in_instr[11:7];
  assign f3     = bus.in_instr[14:12];
  assign rs1    = bus.in_instr[19:15];
  assign rs2    = bus.in_instr[24:20];
  assign f7     = bus.in_instr[31:25];

  regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wr_en    (bus.wb_en),
    .wr_addr  (bus.wb_rd),
    .wr_data  (bus.wb_data)
  );

  always_comb begin
    dec     = '0;
    legal   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OP: begin
        legal      = f7_legal(f3, f7, 1'b0);
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        dec.a      = rs1_data;
        dec.b      = rs2_data;
        dec.funct3 = f3;
        dec.funct7 = f7;
        dec.rd     = rd;
      end
      OP_IMM: begin
        use_rs1    = 1'b1;
        dec.a      = rs1_data;
        dec.funct3 = f3;
        dec.rd     = rd;
        if (f3 == F3_SLL || f3 == F3_SR) begin
          legal      = f7_legal(f3, f7, 1'b1);
          dec.b      = {27'b0, bus.in_instr[24:20]};
          dec.funct7 = f7;
        end else begin
          // Non-shift immediates never carry funct7, so ADDI cannot subtract.
          legal      = 1'b1;
          dec.b      = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
          dec.funct7 = F7_BASE;
        end
      end
      LUI: begin
        legal  = 1'b1;
        dec.b  = {bus.in_instr[31:12], 12'b0};
        dec.rd = rd;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
      use_rs1     = 1'b0;
      use_rs2     = 1'b0;
    end
  end

  // A source retiring this very cycle is served by the regfile bypass.
  assign rs1_busy = pending_reg[rs1] && !(bus.wb_en && bus.wb_rd == rs1);
  assign rs2_busy = pending_reg[rs2] && !(bus.wb_en && bus.wb_rd == rs2);
  assign hazard   = (use_rs1 && rs1_busy) || (use_rs2 && rs2_busy);

  assign in_ready = rst_n && !flush && !hazard && (!out_valid_reg || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    pending_next = pending_reg;
    if (bus.wb_en) pending_next[bus.wb_rd] = 1'b0;
    if (accept && dec.rd != 5'd0) pending_next[dec.rd] = 1'b1;
    if (flush) pending_next = '0;
    pending_next[0] = 1'b0;
  end

  always_comb begin
    out_next       = out_reg;
    out_valid_next = out_valid_reg;
    if (flush) begin
      out_next       = '0;
      out_valid_next = 1'b0;
    end else if (accept) begin
      out_next       = dec;
      out_valid_next = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_reg   <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      pending_reg   <= pending_next;
      out_reg       <= out_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_a       = out_reg.a;
  assign bus.out_b       = out_reg.b;
  assign bus.out_funct3  = out_reg.funct3;
  assign bus.out_funct7  = out_reg.funct7;
  assign bus.out_rd      = out_reg.rd;
  assign bus.out_illegal = out_reg.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes expected ALU bundles,
// a negedge monitor pops and compares whenever the output handshake fires.
module tb_decode_stage;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  decode_stage_if bus();

  decode_stage #(.XLEN(32), .NREG(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  alu_op_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic alu_op_t mk(input logic [31:0] a, input logic [31:0] b,
                                 input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [4:0] rd, input logic ill);
    alu_op_t r;
    r.a = a; r.b = b; r.funct3 = f3; r.funct7 = f7; r.rd = rd; r.illegal = ill;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  // Monitor: one line per consumed output transaction.
  always @(negedge clk) begin
    alu_op_t act;
    alu_op_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      act = mk(bus.out_a, bus.out_b, bus.out_funct3, bus.out_funct7, bus.out_rd, bus.out_illegal);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_out: got a=%h b=%h f3=%0d f7=%h rd=%0d ill=%b, expected nothing",
                 act.a, act.b, act.funct3, act.funct7, act.rd, act.illegal);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_err++;
          $display("FAIL out_rd%0d: got a=%h b=%h f3=%0d f7=%h rd=%0d ill=%b, expected a=%h b=%h f3=%0d f7=%h rd=%0d ill=%b",
                   e.rd, act.a, act.b, act.funct3, act.funct7, act.rd, act.illegal,
                   e.a, e.b, e.funct3, e.funct7, e.rd, e.illegal);
        end else begin
          $display("ok   out: a=%h b=%h f3=%0d f7=%h rd=%0d ill=%b",
                   act.a, act.b, act.funct3, act.funct7, act.rd, act.illegal);
        end
      end
    end
  end

  task automatic send(input logic [31:0] instr, input alu_op_t e, input string name);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: in_ready stuck at 0, expected acceptance", name);
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] data);
    bus.wb_en = 1'b1; bus.wb_rd = rd; bus.wb_data = data;
    @(posedge clk);
    #1 bus.wb_en = 1'b0;
  endtask

  // Presents instr together with a same-cycle writeback and expects acceptance.
  task automatic accept_with_wb(input logic [31:0] instr, input logic [4:0] rd,
                                input logic [31:0] data, input alu_op_t e, input string name);
    bus.in_valid = 1'b1; bus.in_instr = instr;
    bus.wb_en = 1'b1; bus.wb_rd = rd; bus.wb_data = data;
    @(negedge clk);
    check(name, {31'b0, bus.in_ready}, 32'd1);
    if (bus.in_ready) exp_q.push_back(e);
    @(posedge clk);
    #1 bus.in_valid = 1'b0; bus.wb_en = 1'b0;
  endtask

  localparam logic [31:0] I_ADDI_X1  = 32'hFFB0_0093; // addi x1,x0,-5
  localparam logic [31:0] I_SRAI_X3  = 32'h4041_5193; // srai x3,x2,4
  localparam logic [31:0] I_ADDI_X11 = 32'h0010_0593; // addi x11,x0,1
  localparam logic [31:0] I_ADD_X5   = 32'h0020_82B3; // add x5,x1,x2
  localparam logic [31:0] I_SUB_X6   = 32'h4052_8333; // sub x6,x5,x5
  localparam logic [31:0] I_LW_X7    = 32'h0000_A383; // lw x7,0(x1)
  localparam logic [31:0] I_ADDI_X0  = 32'h0003_8013; // addi x0,x7,0
  localparam logic [31:0] I_SLLI_BAD = 32'h4010_9413; // slli x8,x1,1 with funct7=0100000
  localparam logic [31:0] I_LUI_X9   = 32'hABCD_E4B7; // lui x9,0xABCDE
  localparam logic [31:0] I_ADD_X10  = 32'h0004_8533; // add x10,x9,x0

  initial begin
    int n;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.out_ready = 1'b1;
    bus.wb_en = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;

    repeat (2) @(posedge clk);
    bus.in_valid = 1'b1; bus.in_instr = I_ADDI_X11;
    @(negedge clk);
    check("in_ready_in_reset", {31'b0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1; bus.in_valid = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_a", bus.out_a, 32'd0);
    check("rst_out_b", bus.out_b, 32'd0);
    check("rst_out_f3_f7_rd_ill",
          {16'b0, bus.out_funct3, bus.out_funct7, bus.out_rd, bus.out_illegal}, 32'd0);
    @(posedge clk); #1;

    send(I_ADDI_X1, mk(32'h0, 32'hFFFF_FFFB, 3'b000, 7'h00, 5'd1, 1'b0), "addi_x1");
    wb(5'd1, 32'hFFFF_FFFB);
    wb(5'd2, 32'h8000_0000);

    // SRAI held under backpressure for three cycles.
    bus.out_ready = 1'b0;
    send(I_SRAI_X3, mk(32'h8000_0000, 32'h4, 3'b101, 7'h20, 5'd3, 1'b0), "srai_x3");
    bus.in_valid = 1'b1; bus.in_instr = I_ADDI_X11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
      check("hold_a", bus.out_a, 32'h8000_0000);
      check("hold_b", bus.out_b, 32'h4);
      check("hold_f7", {25'b0, bus.out_funct7}, 32'h20);
      check("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0; bus.out_ready = 1'b1;

    // RAW hazard resolved by same-cycle writeback bypass.
    send(I_ADD_X5, mk(32'hFFFF_FFFB, 32'h8000_0000, 3'b000, 7'h00, 5'd5, 1'b0), "add_x5");
    bus.in_valid = 1'b1; bus.in_instr = I_SUB_X6;
    repeat (2) begin
      @(negedge clk);
      check("raw_stall", {31'b0, bus.in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    accept_with_wb(I_SUB_X6, 5'd5, 32'h0000_1234,
                   mk(32'h1234, 32'h1234, 3'b000, 7'h20, 5'd6, 1'b0), "raw_bypass_ready");

    // Illegal instructions: no scoreboard side effect.
    send(I_LW_X7, mk(32'h0, 32'h0, 3'b000, 7'h00, 5'd0, 1'b1), "lw_illegal");
    bus.in_valid = 1'b1; bus.in_instr = I_ADDI_X0;
    @(negedge clk);
    check("after_illegal_ready", {31'b0, bus.in_ready}, 32'd1);
    if (bus.in_ready) exp_q.push_back(mk(32'h0, 32'h0, 3'b000, 7'h00, 5'd0, 1'b0));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    send(I_SLLI_BAD, mk(32'h0, 32'h0, 3'b000, 7'h00, 5'd0, 1'b1), "slli_illegal");

    // Flush while stalled on x5, then replay reads the stored x5.
    send(I_ADD_X5, mk(32'hFFFF_FFFB, 32'h8000_0000, 3'b000, 7'h00, 5'd5, 1'b0), "add_x5_again");
    bus.in_valid = 1'b1; bus.in_instr = I_SUB_X6;
    @(negedge clk);
    check("flush_pre_stall", {31'b0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", {31'b0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("flush_replay_ready", {31'b0, bus.in_ready}, 32'd1);
    if (bus.in_ready) exp_q.push_back(mk(32'h1234, 32'h1234, 3'b000, 7'h20, 5'd6, 1'b0));
    @(posedge clk);
    #1 bus.in_valid = 1'b0;

    // LUI with a simultaneous clear of x9: the set must win.
    accept_with_wb(I_LUI_X9, 5'd9, 32'h0000_0055,
                   mk(32'h0, 32'hABCD_E000, 3'b000, 7'h00, 5'd9, 1'b0), "lui_x9_ready");
    bus.in_valid = 1'b1; bus.in_instr = I_ADD_X10;
    @(negedge clk);
    check("x9_still_pending", {31'b0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    accept_with_wb(I_ADD_X10, 5'd9, 32'h0000_0077,
                   mk(32'h77, 32'h0, 3'b000, 7'h00, 5'd10, 1'b0), "x9_release_ready");

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      n++;
      @(posedge clk);
    end
    @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode/operand stage of the RV32I integer core, directly upstream of `alu`. It accepts one instruction per cycle over a valid/ready handshake and decodes OP, OP-IMM and LUI. It reads a 32×32 register file and registers `a`, `b`, `funct3`, `funct7` and `rd` for the ALU. A per-register scoreboard stalls RAW hazards until the downstream writeback port retires the producer.

## Interface
- `XLEN`, default 32: datapath width; only 32 is supported.
- `NREG`, default 32: architectural register count; x0 is hardwired to zero.
- `clk` input 1: core clock.
- `rst_n` input 1: reset, synchronous, active-low. One clock domain; resets only on the `clk` edge while low.
- `flush` input 1: discard the output-register contents and clear the scoreboard.
- `in_valid` input 1: `in_instr` is valid.
- `in_ready` output 1: stage accepts `in_instr` this cycle.
- `in_instr` input 32: fetched instruction word.
- `out_valid` output 1: ALU operands are valid.
- `out_ready` input 1: downstream consumes the operands this cycle.
- `out_a`, `out_b` output 32: ALU operands.
- `out_funct3` output 3: ALU operation.
- `out_funct7` output 7: ALU modifier; only bit 5 is meaningful.
- `out_rd` output 5: destination register, passed on to writeback.
- `out_illegal` output 1: instruction not supported; `out_rd` is 0.
- `wb_en` input 1: writeback strobe.
- `wb_rd` input 5: writeback register.
- `wb_data` input 32: writeback value.

## Operation
- **Decode by opcode `in_instr[6:0]`:**
  - OP `0110011`: `a=rs1`, `b=rs2`, `funct3=instr[14:12]`, `funct7=instr[31:25]`. `funct7` other than `0000000`, or `0100000` with funct3 ∈ {000,101}, is illegal.
  - OP-IMM `0010011`: `a=rs1`, `b=sext(instr[31:20])`, `funct7=0000000` (bit 5 forced low, so ADDI never subtracts).
  - OP-IMM shifts (funct3 001/101): `b={27'b0, instr[24:20]}` and `funct7=instr[31:25]`. Legal `funct7` values are `0000000` for either shift and `0100000` for 101 only; anything else is illegal.
  - LUI `0110111`: `a=0`, `b={instr[31:12],12'b0}`, funct3=000, funct7=0.
  - Any other opcode is illegal.
- **Illegal instructions:** emitted with `out_illegal=1`, `out_a=out_b=0`, `out_rd=0`, funct3=000, funct7=0. An illegal instruction never sets the scoreboard.
- **Register file:**
  - Reads are combinational and x0 always reads 0.
  - The write occurs on the `clk` edge when `wb_en && wb_rd!=0`.
  - A same-cycle read of `wb_rd` returns `wb_data` (write-through bypass).
- **Scoreboard:**
  - One pending bit per register; bit 0 is constant 0.
  - Set when an instruction with `rd!=0` is accepted.
  - Cleared on the `clk` edge when `wb_en` targets that register.
  - Set and clear of the same register in one cycle: set wins.
- **Hazard stall:** a source register is pending and is not being cleared by `wb_en` this cycle. Only sources actually used are checked: rs1 for OP/OP-IMM, rs2 for OP only, none for LUI or illegal.
- **Acceptance:** `in_ready = !hazard && (!out_valid || out_ready)`. The instruction is accepted on `in_valid && in_ready`.
- **Flush:** the cycle's input is not accepted, `out_valid` clears next edge and all pending bits clear. The register-file write from `wb_en` in that cycle still happens.

## Timing
- Latency is one cycle: an instruction accepted at edge N appears on the outputs after edge N, with `out_valid=1`.
- Outputs are registered and held stable while `out_valid && !out_ready`.
- Full throughput (one instruction/cycle) when there is no hazard and `out_ready=1`.
- **Back-to-back dependent instruction:** stalls until the producer's `wb_en` cycle. It is accepted in that same cycle, using the bypassed `wb_data`.
- **Reset values:** `out_valid=0`, `out_a=out_b=0`, `out_funct3=0`, `out_funct7=0`, `out_rd=0`, `out_illegal=0`, all pending bits 0, all registers 0.
- `in_ready` is 0 while `rst_n=0`.
- **Reset mid-stall** drops the held instruction, and no writeback is applied in that cycle.
- **Priority:** `rst_n` > `flush` > normal operation.

## Structure
- Shared package `core_pkg` holds:
  - opcode constants (`OP`, `OP_IMM`, `LUI`);
  - funct3 encodings for ADD/SLL/SLT/SLTU/XOR/SR/OR/AND;
  - funct7 constants `F7_BASE`, `F7_ALT`;
  - a packed `alu_op_t` struct {a, b, funct3, funct7, rd, illegal}, which is also the output register type.
- One sub-module `regfile`: 2 combinational read ports and 1 synchronous write port, with x0 hardwiring and write-through bypass.
- Decode, scoreboard and output register live in `decode_stage`.

## Test plan
- After reset, `ADDI x1,x0,-5`, with `out_ready=1` → the next cycle gives `out_a=0`, `out_b=0xFFFFFFFB`, funct3=000, funct7=0, `out_rd=1`.
- **SRAI with `out_ready` held:** preload x2=0x80000000 via wb, then `SRAI x3,x2,4` → `out_a=0x80000000`, `out_b=4`, `out_funct7=0100000`. Hold `out_ready=0` for 3 cycles: outputs stable and `in_ready=0`.
- **RAW hazard:** `ADD x5,x1,x2` then `SUB x6,x5,x5` → the second stalls (`in_ready=0`). When `wb_en`, `wb_rd=5`, `wb_data=0x1234` is asserted, it is accepted that cycle with `out_a=out_b=0x1234`, funct7=0100000.
- **Illegal cases:**
  - opcode `0000011` → `out_illegal=1`, `out_rd=0`, and a following `ADDI x0,x7,0` is not stalled;
  - `SLLI` with `instr[31:25]=0100000` → illegal.
- **Flush:** flush while stalled on x5 → pending cleared, `out_valid=0` next cycle. The same instruction is accepted the next cycle, reading the register-file value of x5.
- `LUI x9,0xABCDE` → `out_a=0`, `out_b=0xABCDE000`. Set and clear of x9 in the same cycle leaves x9 pending.
